// File: rtl/alu_8bit.sv
// 8-bit ALU selected by a 15-byte ASCII operation name; {c_out,sum} is
// registered, so each result appears one clock after its inputs are sampled.
module alu_8bit (
  input  logic         clk,
  input  logic         rst,
  input  logic [120:1] oper,
  input  logic [7:0]   a,
  input  logic [7:0]   b,
  input  logic         c_in,
  output logic         c_out,
  output logic [7:0]   sum
);

  // Operation names, right-aligned in 120 bits with zero leading bytes.
  localparam logic [120:1] OP_ADD        = {96'd0, "add"};
  localparam logic [120:1] OP_SUBTRACT   = {56'd0, "subtract"};
  localparam logic [120:1] OP_SUBTRACT_A = {40'd0, "subtract_a"};
  localparam logic [120:1] OP_OR_AB      = {80'd0, "or_ab"};
  localparam logic [120:1] OP_AND_AB     = {72'd0, "and_ab"};
  localparam logic [120:1] OP_NOT_AB     = {72'd0, "not_ab"};
  localparam logic [120:1] OP_EXOR       = {88'd0, "exor"};
  localparam logic [120:1] OP_EXNOR      = {80'd0, "exnor"};

  logic [8:0] a_ext;
  logic [8:0] b_ext;
  logic [8:0] a_inv_ext;
  logic [8:0] b_inv_ext;
  logic [8:0] cin_ext;
  logic [8:0] result_next;

  assign a_ext     = {1'b0, a};
  assign b_ext     = {1'b0, b};
  assign a_inv_ext = {1'b0, ~a};
  assign b_inv_ext = {1'b0, ~b};
  assign cin_ext   = {8'd0, c_in};

  // Full 120-bit compare: anything not listed falls to zero, never X.
  always_comb begin
    result_next = 9'h000;
    case (oper)
      OP_ADD:        result_next = a_ext + b_ext + cin_ext;
      OP_SUBTRACT:   result_next = a_ext + b_inv_ext + cin_ext;
      OP_SUBTRACT_A: result_next = b_ext + a_inv_ext + cin_ext;
      OP_OR_AB:      result_next = {1'b0, a | b};
      OP_AND_AB:     result_next = {1'b0, a & b};
      OP_NOT_AB:     result_next = {1'b0, (~a) & b};
      OP_EXOR:       result_next = {1'b0, a ^ b};
      OP_EXNOR:      result_next = {1'b0, ~(a ^ b)};
      default:       result_next = 9'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {c_out, sum} <= 9'h000;
    end else begin
      {c_out, sum} <= result_next;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: the driver pushes hand-computed
// {c_out,sum} values into a queue, the monitor pops one per issued cycle.
module tb_alu_8bit;

  localparam logic [120:1] OP_ADD        = {96'd0, "add"};
  localparam logic [120:1] OP_SUBTRACT   = {56'd0, "subtract"};
  localparam logic [120:1] OP_SUBTRACT_A = {40'd0, "subtract_a"};
  localparam logic [120:1] OP_OR_AB      = {80'd0, "or_ab"};
  localparam logic [120:1] OP_AND_AB     = {72'd0, "and_ab"};
  localparam logic [120:1] OP_NOT_AB     = {72'd0, "not_ab"};
  localparam logic [120:1] OP_EXOR       = {88'd0, "exor"};
  localparam logic [120:1] OP_EXNOR      = {80'd0, "exnor"};
  localparam logic [120:1] OP_AND        = {96'd0, "and"};
  localparam logic [120:1] OP_EMPTY      = 120'd0;
  localparam logic [120:1] OP_ADD_UPPER  = {96'd0, "ADD"};
  localparam logic [120:1] OP_ADD_TRAIL  = {88'd0, "add "};
  localparam logic [120:1] OP_ADD_LEAD   = {88'd0, "xadd"};
  localparam logic [120:1] OP_ADD_SHIFT  = {88'd0, "add", 8'd0};

  logic         clk;
  logic         rst;
  logic [120:1] oper;
  logic [7:0]   a;
  logic [7:0]   b;
  logic         c_in;
  logic         c_out;
  logic [7:0]   sum;

  logic [8:0]   exp_q[$];
  string        name_q[$];
  logic         drv_valid;
  logic         mon_valid;
  int           pass_cnt;
  int           total_cnt;

  alu_8bit dut (
    .clk   (clk),
    .rst   (rst),
    .oper  (oper),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .c_out (c_out),
    .sum   (sum)
  );

  // Clock and reset-free startup values
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst       = 1'b1;
    oper      = OP_EMPTY;
    a         = 8'h00;
    b         = 8'h00;
    c_in      = 1'b0;
    drv_valid = 1'b0;
    mon_valid = 1'b0;
    pass_cnt  = 0;
    total_cnt = 0;
  end

  // Driver tasks: inputs change on the falling edge, away from sampling.
  task automatic issue(input logic r, input logic [120:1] op, input logic [7:0] va,
                       input logic [7:0] vb, input logic ci, input logic [8:0] expv,
                       input string name);
    @(negedge clk);
    rst       = r;
    oper      = op;
    a         = va;
    b         = vb;
    c_in      = ci;
    drv_valid = 1'b1;
    exp_q.push_back(expv);
    name_q.push_back(name);
  endtask

  task automatic idle();
    @(negedge clk);
    rst       = 1'b0;
    oper      = OP_EMPTY;
    drv_valid = 1'b0;
  endtask

  // Scoreboard monitor: an issued cycle's result is visible after the next edge.
  always @(posedge clk) mon_valid <= drv_valid;

  always @(negedge clk) begin
    if (mon_valid) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL no_expected: output %b_%h with empty queue", c_out, sum);
      end else begin
        logic [8:0] expv;
        string      nm;
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        if ({c_out, sum} !== expv)
          $display("FAIL %s: got %b_%h expected %b_%h", nm, c_out, sum, expv[8], expv[7:0]);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    // Reset state
    issue(1'b1, OP_ADD, 8'hFF, 8'hFF, 1'b1, 9'h000, "reset_0");
    issue(1'b1, OP_EXOR, 8'h12, 8'h34, 1'b0, 9'h000, "reset_1");

    // Subtract variants
    issue(1'b0, OP_SUBTRACT,   8'h0C, 8'h20, 1'b1, 9'h0EC, "sub_0c_20");
    issue(1'b0, OP_SUBTRACT_A, 8'hA4, 8'h2A, 1'b0, 9'h085, "suba_a4_2a");
    issue(1'b0, OP_SUBTRACT,   8'h00, 8'h01, 1'b1, 9'h0FF, "sub_borrow");
    issue(1'b0, OP_SUBTRACT,   8'h10, 8'h10, 1'b0, 9'h0FF, "sub_cin0");

    // Add with wrap-around
    issue(1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    issue(1'b0, OP_ADD, 8'h7F, 8'h80, 1'b1, 9'h100, "add_7f_80_c");
    issue(1'b0, OP_ADD, 8'h10, 8'h20, 1'b1, 9'h031, "add_10_20_c");

    // Logical ops, c_in ignored
    for (int ci = 0; ci < 2; ci++) begin
      issue(1'b0, OP_OR_AB,  8'hEC, 8'hA6, ci[0], 9'h0EE, "or_ab");
      issue(1'b0, OP_AND_AB, 8'h2F, 8'h6A, ci[0], 9'h02A, "and_ab");
      issue(1'b0, OP_NOT_AB, 8'h66, 8'h02, ci[0], 9'h000, "not_ab");
      issue(1'b0, OP_EXOR,   8'h4B, 8'hF7, ci[0], 9'h0BC, "exor");
      issue(1'b0, OP_EXNOR,  8'h6C, 8'h2F, ci[0], 9'h0BC, "exnor");
    end

    // Unrecognised names
    issue(1'b0, OP_AND,       8'h0C, 8'h0C, 1'b0, 9'h000, "bad_and");
    issue(1'b0, OP_EMPTY,     8'hFF, 8'hFF, 1'b1, 9'h000, "bad_empty");
    issue(1'b0, OP_ADD_UPPER, 8'h01, 8'h01, 1'b0, 9'h000, "bad_upper");
    issue(1'b0, OP_ADD_TRAIL, 8'h01, 8'h01, 1'b0, 9'h000, "bad_trail");
    issue(1'b0, OP_ADD_LEAD,  8'h01, 8'h01, 1'b0, 9'h000, "bad_lead");
    issue(1'b0, OP_ADD_SHIFT, 8'h01, 8'h01, 1'b0, 9'h000, "bad_shift");

    // Back-to-back, a new op every cycle
    issue(1'b0, OP_ADD,        8'h01, 8'h02, 1'b0, 9'h003, "b2b_add");
    issue(1'b0, OP_SUBTRACT,   8'h05, 8'h03, 1'b1, 9'h102, "b2b_sub");
    issue(1'b0, OP_SUBTRACT_A, 8'h05, 8'h03, 1'b1, 9'h0FE, "b2b_suba");
    issue(1'b0, OP_OR_AB,      8'hF0, 8'h0F, 1'b1, 9'h0FF, "b2b_or");
    issue(1'b0, OP_AND_AB,     8'hF0, 8'h3C, 1'b0, 9'h030, "b2b_and");
    issue(1'b0, OP_NOT_AB,     8'hF0, 8'hFF, 1'b1, 9'h00F, "b2b_not");
    issue(1'b0, OP_EXOR,       8'hAA, 8'h55, 1'b0, 9'h0FF, "b2b_exor");
    issue(1'b0, OP_EXNOR,      8'hAA, 8'h55, 1'b1, 9'h000, "b2b_exnor");

    // Mid-stream reset overrides a valid exor, then exor resumes
    issue(1'b0, OP_ADD,  8'hFF, 8'h01, 1'b0, 9'h100, "rst_pre_add");
    issue(1'b1, OP_EXOR, 8'h4B, 8'hF7, 1'b0, 9'h000, "rst_override");
    issue(1'b0, OP_EXOR, 8'h4B, 8'hF7, 1'b0, 9'h0BC, "rst_resume");

    idle();
    idle();
    idle();

    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    else
      pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 oper  input  120 ([120:1])  operation name as 15-byte ASCII string, right-aligned, unused leading bytes zero.
REQ-005 a  input  8  operand A, unsigned.
REQ-006 b  input  8  operand B, unsigned.
REQ-007 c_in  input  1  carry/borrow-in; used by arithmetic ops only.
REQ-008 c_out  output  1  registered carry-out.
REQ-009 sum  output  8  registered result.

Function
REQ-010 Output pair {c_out,sum} (9 bits) SHALL be registered; new result visible one rising clk after inputs are sampled (latency 1, throughput 1 per cycle).
REQ-011 Decode SHALL compare all 120 bits of oper exactly; no partial/prefix or case-insensitive match.
REQ-012 "add": {c_out,sum} = a + b + c_in, 9-bit unsigned.
REQ-013 "subtract": {c_out,sum} = a + ~b + c_in, 9-bit unsigned (c_in=1 gives a-b; c_out=1 means no borrow).
REQ-014 "subtract_a": {c_out,sum} = b + ~a + c_in, 9-bit unsigned.
REQ-015 "or_ab": sum = a | b; c_out = 0.
REQ-016 "and_ab": sum = a & b; c_out = 0.
REQ-017 "not_ab": sum = (~a) & b; c_out = 0.
REQ-018 "exor": sum = a ^ b; c_out = 0.
REQ-019 "exnor": sum = ~(a ^ b); c_out = 0.
REQ-020 Any other oper value (including "and", "", or trailing/leading garbage) SHALL load {c_out,sum} = 9'h000; never X.
REQ-021 c_in SHALL be ignored by logical ops.
REQ-022 Arithmetic wrap-around: results above 8 bits SHALL appear only in c_out; sum is low 8 bits.
REQ-023 Inputs may change every cycle; each cycle's result depends only on inputs sampled at that edge (no internal state besides the output register).

Reset
REQ-024 When rst=1 at a rising clk, {c_out,sum} SHALL load 9'h000, overriding any operation that cycle.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; first valid result appears one clk after the first edge with rst=0.
REQ-026 Before the first reset, output value is undefined; benches SHALL reset first.

Verification
REQ-027 oper="subtract", a=0x0C, b=0x20, c_in=1 -> next edge {c_out,sum}=0_0xEC; oper="subtract_a", a=0xA4, b=0x2A, c_in=0 -> 0_0x85.
REQ-028 oper="add", a=0xFF, b=0x01, c_in=0 -> 1_0x00; a=0x7F, b=0x80, c_in=1 -> 1_0x00; a=0x10, b=0x20, c_in=1 -> 0_0x31.
REQ-029 Logical: "or_ab" a=0xEC b=0xA6 -> 0_0xEE; "and_ab" a=0x2F b=0x6A -> 0_0x2A; "not_ab" a=0x66 b=0x02 -> 0_0x00; "exor" a=0x4B b=0xF7 -> 0_0xBC; "exnor" a=0x6C b=0x2F -> 0_0xBC; each with c_in=1 gives the same result.
REQ-030 Unrecognized oper="and", a=0x0C, b=0x0C -> 0_0x00 (no X on outputs).
REQ-031 Back-to-back: change op/operands every cycle for 8 cycles -> each result appears exactly one cycle later, matching REQ-012..REQ-020.
REQ-032 Reset: produce 1_0x00 via add, then assert rst for one edge with valid "exor" inputs -> output 0_0x00; deassert -> exor result one edge later.
